// File: rtl/fib_chk_pkg.sv
// Shared types and constants for the fib accumulator step checker.
package fib_chk_pkg;

    localparam int DEF_WIDTH = 11;
    localparam int DEF_LIMIT = 300;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_XY    = 3'd1;
    localparam logic [2:0] ERR_XSTEP = 3'd2;
    localparam logic [2:0] ERR_ISTEP = 3'd3;
    localparam logic [2:0] ERR_JSTEP = 3'd4;
    localparam logic [2:0] ERR_JLTI  = 3'd5;
    localparam logic [2:0] ERR_DELTA = 3'd6;

endpackage

// File: rtl/fib_step_model.sv
// Combinational prediction of the upstream accumulator's next x, y, i, j from the previous sample.
// Advances only while the previous j is below LIMIT; otherwise predicts a frozen state.
import fib_chk_pkg::*;

module fib_step_model #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMIT = DEF_LIMIT
) (
    input  logic [WIDTH-1:0] i_px,
    input  logic [WIDTH-1:0] i_py,
    input  logic [WIDTH-1:0] i_pi,
    input  logic [WIDTH-1:0] i_pj,
    input  logic             i_psel,
    output logic [WIDTH-1:0] o_nx,
    output logic [WIDTH-1:0] o_ny,
    output logic [WIDTH-1:0] o_ni,
    output logic [WIDTH-1:0] o_nj,
    output logic             o_adv
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic w_adv;

    assign w_adv = (i_pj < LIM);
    assign o_adv = w_adv;

    always_comb begin
        o_nx = i_px;
        o_ny = i_py;
        o_ni = i_pi;
        o_nj = i_pj;
        if (w_adv) begin
            o_nx = i_px + ONE;
            o_ny = i_py + ONE;
            // i accumulates the new x; j the new y plus one extra per selector-low step
            o_ni = i_pi + i_px + ONE;
            o_nj = i_pj + i_py + ONE + (i_psel ? '0 : ONE);
        end
    end

endmodule

// File: rtl/fib_step_checker.sv
// Monitors the fib accumulator stage; sticky fail with first error code, step/low counters.
// Define FIB_CHK_FAIL_CAPTURE_EN to latch i/j at the first failure into o_fail_i/o_fail_j.
import fib_chk_pkg::*;

module fib_step_checker #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMIT = DEF_LIMIT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_src_rst,
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_i,
    input  logic [WIDTH-1:0] i_j,
    output logic             o_ok,
    output logic             o_done,
    output logic             o_fail,
    output logic [2:0]       o_err_code,
    output logic [CNT_W-1:0] o_step_cnt,
    output logic [CNT_W-1:0] o_low_cnt,
    output logic [WIDTH-1:0] o_fail_i,
    output logic [WIDTH-1:0] o_fail_j
);

    localparam logic [WIDTH-1:0] LIM   = WIDTH'(LIMIT);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_px, r_py, r_pi, r_pj;
    logic             r_psel;
    logic [2:0]       r_err, w_err_nxt, w_err;
    logic [CNT_W-1:0] r_step_cnt, r_low_cnt, w_step_nxt, w_low_nxt;
    logic [CNT_W-1:0] w_step_inc, w_low_inc;
    logic [WIDTH-1:0] w_nx, w_ny, w_ni, w_nj;
    logic [WIDTH-1:0] w_ex, w_ey, w_ei, w_ej, w_diff;
    logic             w_adv, w_stepping;

    fib_step_model #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_model (
        .i_px   (r_px),
        .i_py   (r_py),
        .i_pi   (r_pi),
        .i_pj   (r_pj),
        .i_psel (r_psel),
        .o_nx   (w_nx),
        .o_ny   (w_ny),
        .o_ni   (w_ni),
        .o_nj   (w_nj),
        .o_adv  (w_adv)
    );

    // DONE only ever checks against a frozen upstream
    assign w_ex = (r_state == DONE) ? r_px : w_nx;
    assign w_ey = (r_state == DONE) ? r_py : w_ny;
    assign w_ei = (r_state == DONE) ? r_pi : w_ni;
    assign w_ej = (r_state == DONE) ? r_pj : w_nj;

    assign w_stepping = (r_state == RUN) && w_adv;
    assign w_step_inc = (w_stepping && r_step_cnt != '1) ? r_step_cnt + C_ONE : r_step_cnt;
    assign w_low_inc  = (w_stepping && !r_psel && r_low_cnt != '1) ? r_low_cnt + C_ONE : r_low_cnt;
    assign w_diff     = i_j - i_i;

    always_comb begin
        w_err = ERR_NONE;
        if (i_x != i_y)                          w_err = ERR_XY;
        else if (i_x != w_ex || i_y != w_ey)     w_err = ERR_XSTEP;
        else if (i_i != w_ei)                    w_err = ERR_ISTEP;
        else if (i_j != w_ej)                    w_err = ERR_JSTEP;
        else if (i_j < i_i)                      w_err = ERR_JLTI;
        else if (w_diff != WIDTH'(w_low_inc))    w_err = ERR_DELTA;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_step_nxt  = r_step_cnt;
        w_low_nxt   = r_low_cnt;
        if (i_src_rst) begin
            w_state_nxt = INIT;
            w_err_nxt   = ERR_NONE;
            w_step_nxt  = '0;
            w_low_nxt   = '0;
        end else begin
            case (r_state)
                INIT: w_state_nxt = RUN;
                RUN, DONE: begin
                    if (w_err != ERR_NONE) begin
                        w_state_nxt = FAIL;
                        w_err_nxt   = w_err;
                    end else begin
                        w_step_nxt = w_step_inc;
                        w_low_nxt  = w_low_inc;
                        if (r_state == RUN && i_j >= LIM) w_state_nxt = DONE;
                    end
                end
                FAIL:    w_state_nxt = FAIL;
                default: w_state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= INIT;
            r_err      <= ERR_NONE;
            r_step_cnt <= '0;
            r_low_cnt  <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_pi       <= '0;
            r_pj       <= '0;
            r_psel     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_err      <= w_err_nxt;
            r_step_cnt <= w_step_nxt;
            r_low_cnt  <= w_low_nxt;
            r_px       <= i_x;
            r_py       <= i_y;
            r_pi       <= i_i;
            r_pj       <= i_j;
            r_psel     <= i_sel;
        end
    end

    assign o_ok       = (r_state == RUN) || (r_state == DONE);
    assign o_done     = (r_state == DONE);
    assign o_fail     = (r_state == FAIL);
    assign o_err_code = r_err;
    assign o_step_cnt = r_step_cnt;
    assign o_low_cnt  = r_low_cnt;

`ifdef FIB_CHK_FAIL_CAPTURE_EN
    logic [WIDTH-1:0] r_fail_i, r_fail_j;
    logic             w_cap;

    assign w_cap = (w_state_nxt == FAIL) && (r_state != FAIL);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_fail_i <= '0;
            r_fail_j <= '0;
        end else if (i_src_rst) begin
            r_fail_i <= '0;
            r_fail_j <= '0;
        end else if (w_cap) begin
            r_fail_i <= i_i;
            r_fail_j <= i_j;
        end
    end

    assign o_fail_i = r_fail_i;
    assign o_fail_j = r_fail_j;
`else
    assign o_fail_i = '0;
    assign o_fail_j = '0;
`endif

endmodule
